// File: rtl/rram_write_verify_ctrl_if.sv
// Request/response channel bundle for the RRAM write-verify controller.
// The requester holds the master modport; the controller holds the slave.
interface rram_write_verify_ctrl_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 6,
   parameter int RETRY_W    = 2
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [DATA_WIDTH-1:0] resp_rdata;
   logic                  resp_fail;
   logic [RETRY_W-1:0]    resp_retries;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_fail, resp_retries
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_fail, resp_retries
   );
endinterface

// File: rtl/rram_write_verify_ctrl.sv
// Write-verify controller for a single-port RW RRAM macro: each write is
// read back and re-issued on mismatch, bounded by MAX_RETRY re-writes.
module rram_write_verify_ctrl #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 6,
   parameter int MAX_RETRY  = 3,
   parameter int RETRY_W    = 2
) (
   input  logic                   i_clk0,
   input  logic                   i_rst0,
   rram_write_verify_ctrl_if.slave bus,
   output logic                   o_csb0,
   output logic                   o_web0,
   output logic [ADDR_WIDTH-1:0]  o_addr0,
   output logic [DATA_WIDTH-1:0]  o_din0,
   input  logic [DATA_WIDTH-1:0]  i_dout0
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_VRD,
      S_VCHK,
      S_RD,
      S_RCAP,
      S_RESP
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  w_accept;
   logic                  w_match;
   logic                  w_retry_ok;

   logic                  r_csb0;
   logic                  r_web0;
   logic [ADDR_WIDTH-1:0] r_addr0;
   logic [DATA_WIDTH-1:0] r_din0;
   logic [RETRY_W-1:0]    r_retry;
   logic                  r_resp_valid;
   logic [DATA_WIDTH-1:0] r_resp_rdata;
   logic                  r_resp_fail;
   logic [RETRY_W-1:0]    r_resp_retries;

   // din0 doubles as the latched write data used for the verify compare
   assign w_match    = (i_dout0 == r_din0);
   assign w_retry_ok = (r_retry < RETRY_W'(MAX_RETRY));
   assign w_accept   = (r_state == S_IDLE) && bus.req_valid;

   always_ff @(posedge i_clk0) begin
      if (i_rst0) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (bus.req_valid) begin
               w_next = bus.req_write ? S_WR : S_RD;
            end
         end
         S_WR:   w_next = S_VRD;
         S_VRD:  w_next = S_VCHK;
         S_VCHK: begin
            if (w_match || !w_retry_ok) begin
               w_next = S_RESP;
            end else begin
               w_next = S_WR;
            end
         end
         S_RD:   w_next = S_RCAP;
         S_RCAP: w_next = S_RESP;
         S_RESP: begin
            if (bus.resp_ready) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Macro command registered from the next state so it is stable for the whole state cycle
   always_ff @(posedge i_clk0) begin
      if (i_rst0) begin
         r_csb0         <= 1'b1;
         r_web0         <= 1'b1;
         r_addr0        <= '0;
         r_din0         <= '0;
         r_retry        <= '0;
         r_resp_valid   <= 1'b0;
         r_resp_rdata   <= '0;
         r_resp_fail    <= 1'b0;
         r_resp_retries <= '0;
      end else begin
         r_csb0       <= !(w_next inside {S_WR, S_VRD, S_RD});
         r_web0       <= (w_next != S_WR);
         r_resp_valid <= (w_next == S_RESP);
         if (w_accept) begin
            r_addr0 <= bus.req_addr;
            r_din0  <= bus.req_wdata;
            r_retry <= '0;
         end
         if (r_state == S_VCHK) begin
            r_resp_rdata <= i_dout0;
            r_resp_fail  <= !w_match && !w_retry_ok;
            if (!w_match && w_retry_ok) begin
               r_retry <= r_retry + 1'b1;
            end
         end
         if (r_state == S_RCAP) begin
            r_resp_rdata <= i_dout0;
            r_resp_fail  <= 1'b0;
         end
         if ((w_next == S_RESP) && (r_state != S_RESP)) begin
            r_resp_retries <= r_retry;
         end
      end
   end

   assign bus.req_ready    = (r_state == S_IDLE) && !i_rst0;
   assign bus.resp_valid   = r_resp_valid;
   assign bus.resp_rdata   = r_resp_rdata;
   assign bus.resp_fail    = r_resp_fail;
   assign bus.resp_retries = r_resp_retries;

   assign o_csb0  = r_csb0;
   assign o_web0  = r_web0;
   assign o_addr0 = r_addr0;
   assign o_din0  = r_din0;

endmodule

// File: tb/tb_rram_write_verify_ctrl.sv
// Randomized bench for rram_write_verify_ctrl with a faulty-macro model
// and a transaction-level reference of the write-verify outcome.
module tb_rram_write_verify_ctrl;
   localparam int DW = 64;
   localparam int AW = 6;
   localparam int MR = 3;
   localparam int RW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          csb;
   logic          web;
   logic [AW-1:0] addr0;
   logic [DW-1:0] din0;
   logic [DW-1:0] dout0;

   always #5 clk = ~clk;

   rram_write_verify_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RETRY_W(RW)) bus ();

   rram_write_verify_ctrl #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_RETRY(MR), .RETRY_W(RW)
   ) dut (
      .i_clk0(clk), .i_rst0(rst), .bus(bus),
      .o_csb0(csb), .o_web0(web), .o_addr0(addr0), .o_din0(din0), .i_dout0(dout0)
   );

   // Macro model: writes below fault_limit land with bit 0 flipped
   logic [DW-1:0] mem [0:(1<<AW)-1];
   int            wr_seen = 0;
   int            fault_limit = 0;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < (1<<AW); i++) mem[i] <= '0;
         dout0 <= '0;
      end else if (!csb) begin
         if (!web) begin
            mem[addr0] <= (wr_seen < fault_limit) ? (din0 ^ 64'd1) : din0;
            wr_seen    <= wr_seen + 1;
         end else begin
            dout0 <= mem[addr0];
         end
      end
   end

   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   int            n_chk = 0;
   int            n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // k = number of leading writes the macro corrupts for this request
   task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int k, input int hold);
      int            base;
      int            lat;
      int            n;
      int            exp_ret;
      bit            exp_fail;
      logic [DW-1:0] exp_data;
      if (wr) begin
         exp_fail = (k > MR);
         exp_ret  = exp_fail ? MR : k;
         exp_data = exp_fail ? (d ^ 64'd1) : d;
      end else begin
         exp_fail = 1'b0;
         exp_ret  = 0;
         exp_data = ref_mem[a];
      end
      base = wr_seen;
      fault_limit = wr_seen + k;
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = a;
      bus.req_wdata = d;
      n = 0;
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) chk("accept_timeout", 64'd0, 64'd1);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            bus.req_valid = 1'b0;
            bus.req_write = ~wr;
            bus.req_addr  = AW'($urandom);
            bus.req_wdata = {$urandom, $urandom};
         end
      end while (!bus.resp_valid && lat < 40);
      chk("latency", 64'(lat), 64'(wr ? 4 + 3 * exp_ret : 3));
      for (int h = 0; h <= hold; h++) begin
         chk("resp_valid", 64'(bus.resp_valid), 64'd1);
         chk("resp_rdata", bus.resp_rdata, exp_data);
         chk("resp_fail", 64'(bus.resp_fail), 64'(exp_fail));
         chk("resp_retries", 64'(bus.resp_retries), 64'(exp_ret));
         chk("busy_ready", 64'(bus.req_ready), 64'd0);
         chk("resp_csb", 64'(csb), 64'd1);
         if (h == hold) bus.resp_ready = 1'b1;
         @(negedge clk);
      end
      bus.resp_ready = 1'b0;
      chk("resp_drop", 64'(bus.resp_valid), 64'd0);
      chk("idle_ready", 64'(bus.req_ready), 64'd1);
      chk("wr_cmds", 64'(wr_seen - base), 64'(wr ? exp_ret + 1 : 0));
      if (wr) ref_mem[a] = exp_data;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < (1<<AW); i++) ref_mem[i] = '0;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.resp_ready = 1'b0;

      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_csb", 64'(csb), 64'd1);
      chk("rst_web", 64'(web), 64'd1);
      chk("rst_addr", 64'(addr0), 64'd0);
      chk("rst_din", din0, 64'd0);
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("rst_rdata", bus.resp_rdata, 64'd0);
      chk("rst_fail", 64'(bus.resp_fail), 64'd0);
      chk("rst_retries", 64'(bus.resp_retries), 64'd0);
      chk("rst_ready", 64'(bus.req_ready), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 64'(bus.req_ready), 64'd1);

      do_req(1'b1, 6'd5, 64'hDEADBEEF_CAFEF00D, 0, 0);
      do_req(1'b0, 6'd5, 64'd0, 0, 0);
      do_req(1'b1, 6'd12, 64'h0123_4567_89AB_CDEF, 2, 0);
      do_req(1'b1, 6'd20, 64'hFFFF_0000_FFFF_0000, 1000, 0);
      do_req(1'b0, 6'd20, 64'd0, 0, 0);
      do_req(1'b0, 6'd5, 64'd0, 0, 5);

      // abort a write in VRD; the macro model clears on reset, so does the reference
      fault_limit = wr_seen;
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 6'd9;
      bus.req_wdata = 64'h5555_AAAA_5555_AAAA;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_csb", 64'(csb), 64'd1);
      chk("abort_resp", 64'(bus.resp_valid), 64'd0);
      chk("abort_ready", 64'(bus.req_ready), 64'd0);
      rst = 1'b0;
      for (int i = 0; i < (1<<AW); i++) ref_mem[i] = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_quiet_resp", 64'(bus.resp_valid), 64'd0);
         chk("abort_quiet_csb", 64'(csb), 64'd1);
      end
      do_req(1'b1, 6'd9, 64'h1111_2222_3333_4444, 0, 1);

      for (int t = 0; t < 60; t++) begin
         bit            wr;
         logic [AW-1:0] a;
         logic [DW-1:0] d;
         int            k;
         wr = 1'($urandom_range(0, 1));
         a  = AW'($urandom_range(0, (1<<AW) - 1));
         d  = {$urandom, $urandom};
         k  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
         do_req(wr, a, d, k, int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
